// File: rtl/riffa_reg_rd_responder.sv
// Host-read responder for the channel register file: captures one 1-DW read,
// looks up the register value and returns a single completion.
module riffa_reg_rd_responder #(
  parameter int          C_NUM_CHNL         = 12,
  parameter int          C_CHNL_W           = 4,
  parameter logic [31:0] C_FPGA_NAME        = 32'h52494641,
  parameter int          TAG_W              = 8,
  parameter int          REQID_W            = 16,
  parameter int          LEN_W              = 10,
  parameter int          LOWADDR_W          = 7,
  parameter int          OFFSET_W           = 4,
  parameter int          CPLID_W            = 16,
  parameter int          SIG_CORESETTINGS_W = 32,
  parameter int          STAT_W             = 3,
  parameter int          BYTECNT_W          = 12
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [TAG_W-1:0]              req_tag,
  input  logic [REQID_W-1:0]            req_reqid,
  input  logic [LEN_W-1:0]              req_len,
  input  logic [LOWADDR_W-1:0]          req_lowaddr,
  input  logic [C_CHNL_W-1:0]           req_chnl,
  input  logic [OFFSET_W-1:0]           req_offset,
  input  logic [CPLID_W-1:0]            cfg_cplid,
  input  logic [SIG_CORESETTINGS_W-1:0] core_settings,
  input  logic [63:0]                   intr_vector,
  input  logic [32*C_NUM_CHNL-1:0]      tx_len,
  input  logic [32*C_NUM_CHNL-1:0]      tx_offlast,
  input  logic [32*C_NUM_CHNL-1:0]      rx_len_xferd,
  input  logic [32*C_NUM_CHNL-1:0]      tx_len_xferd,
  output logic [1:0]                    intr_rd,
  output logic [C_NUM_CHNL-1:0]         tx_len_rd,
  output logic                          cpl_valid,
  input  logic                          cpl_ready,
  output logic [TAG_W-1:0]              cpl_tag,
  output logic [REQID_W-1:0]            cpl_reqid,
  output logic [CPLID_W-1:0]            cpl_cplid,
  output logic [STAT_W-1:0]             cpl_status,
  output logic [LEN_W-1:0]              cpl_len,
  output logic [BYTECNT_W-1:0]          cpl_bytecnt,
  output logic [LOWADDR_W-1:0]          cpl_lowaddr,
  output logic [31:0]                   cpl_data
);

  typedef enum logic [1:0] {S_IDLE, S_CAP, S_CPL} state_t;

  state_t                  state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic [REQID_W-1:0]      reqid_q, reqid_d;
  logic [LEN_W-1:0]        req_len_q, req_len_d;
  logic [LOWADDR_W-1:0]    lowaddr_q, lowaddr_d;
  logic [C_CHNL_W-1:0]     chnl_q, chnl_d;
  logic [OFFSET_W-1:0]     offset_q, offset_d;
  logic [CPLID_W-1:0]      cplid_q, cplid_d;
  logic [STAT_W-1:0]       status_q, status_d;
  logic [LEN_W-1:0]        cpl_len_q, cpl_len_d;
  logic [BYTECNT_W-1:0]    bytecnt_q, bytecnt_d;
  logic [31:0]             data_q, data_d;
  logic [1:0]              intr_pend_q, intr_pend_d;
  logic [C_NUM_CHNL-1:0]   txlen_pend_q, txlen_pend_d;
  logic                    sc;
  logic [31:0]             reg_val;
  logic                    cpl_hs;

  // Out-of-range channels match no slot and therefore read as zero.
  function automatic logic [31:0] chnl_word(input logic [32*C_NUM_CHNL-1:0] bus,
                                            input logic [C_CHNL_W-1:0] ch);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < C_NUM_CHNL; i++)
      if (ch == C_CHNL_W'(i)) w = bus[32*i +: 32];
    return w;
  endfunction

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    reqid_d      = reqid_q;
    req_len_d    = req_len_q;
    lowaddr_d    = lowaddr_q;
    chnl_d       = chnl_q;
    offset_d     = offset_q;
    cplid_d      = cplid_q;
    status_d     = status_q;
    cpl_len_d    = cpl_len_q;
    bytecnt_d    = bytecnt_q;
    data_d       = data_q;
    intr_pend_d  = intr_pend_q;
    txlen_pend_d = txlen_pend_q;
    sc           = (req_len_q == LEN_W'(1));
    reg_val      = '0;

    case (offset_q)
      OFFSET_W'(8):  reg_val = chnl_word(tx_len, chnl_q);
      OFFSET_W'(9):  reg_val = chnl_word(tx_offlast, chnl_q);
      OFFSET_W'(10): reg_val = 32'(core_settings);
      OFFSET_W'(11): reg_val = intr_vector[31:0];
      OFFSET_W'(12): reg_val = intr_vector[63:32];
      OFFSET_W'(13): reg_val = chnl_word(rx_len_xferd, chnl_q);
      OFFSET_W'(14): reg_val = chnl_word(tx_len_xferd, chnl_q);
      OFFSET_W'(15): reg_val = C_FPGA_NAME;
      default:       reg_val = '0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          tag_d     = req_tag;
          reqid_d   = req_reqid;
          req_len_d = req_len;
          lowaddr_d = req_lowaddr;
          chnl_d    = req_chnl;
          offset_d  = req_offset;
          cplid_d   = cfg_cplid;
          state_d   = S_CAP;
        end
      end
      S_CAP: begin
        status_d     = sc ? STAT_W'(0) : STAT_W'(1);
        cpl_len_d    = sc ? LEN_W'(1) : LEN_W'(0);
        bytecnt_d    = sc ? BYTECNT_W'(4) : BYTECNT_W'(0);
        data_d       = sc ? reg_val : 32'h0;
        intr_pend_d  = {sc && (offset_q == OFFSET_W'(12)), sc && (offset_q == OFFSET_W'(11))};
        txlen_pend_d = (sc && (offset_q == OFFSET_W'(8)))
                       ? (C_NUM_CHNL'(1) << chnl_q) : '0;
        state_d      = S_CPL;
      end
      S_CPL: begin
        if (cpl_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      tag_q        <= '0;
      reqid_q      <= '0;
      req_len_q    <= '0;
      lowaddr_q    <= '0;
      chnl_q       <= '0;
      offset_q     <= '0;
      cplid_q      <= '0;
      status_q     <= '0;
      cpl_len_q    <= '0;
      bytecnt_q    <= '0;
      data_q       <= '0;
      intr_pend_q  <= '0;
      txlen_pend_q <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      tag_q        <= tag_d;
      reqid_q      <= reqid_d;
      req_len_q    <= req_len_d;
      lowaddr_q    <= lowaddr_d;
      chnl_q       <= chnl_d;
      offset_q     <= offset_d;
      cplid_q      <= cplid_d;
      status_q     <= status_d;
      cpl_len_q    <= cpl_len_d;
      bytecnt_q    <= bytecnt_d;
      data_q       <= data_d;
      intr_pend_q  <= intr_pend_d;
      txlen_pend_q <= txlen_pend_d;
    end
  end

  // Read-side-effect pulses fire only in the handshake cycle of the completion.
  assign cpl_valid   = (state_q == S_CPL);
  assign cpl_hs      = cpl_valid && cpl_ready;
  assign intr_rd     = intr_pend_q & {2{cpl_hs}};
  assign tx_len_rd   = txlen_pend_q & {C_NUM_CHNL{cpl_hs}};
  assign req_ready   = req_ready_q;
  assign cpl_tag     = tag_q;
  assign cpl_reqid   = reqid_q;
  assign cpl_cplid   = cplid_q;
  assign cpl_status  = status_q;
  assign cpl_len     = cpl_len_q;
  assign cpl_bytecnt = bytecnt_q;
  assign cpl_lowaddr = lowaddr_q;
  assign cpl_data    = data_q;

endmodule
